// File: rtl/sng_lfsr8.sv
// rtl/sng_lfsr8.sv - binary-to-stochastic number generator, 256-cycle stream from an 8-bit value
// The full-period LFSR visits every 8-bit value once per stream, so (lfsr < x_reg) is true exactly x_reg times.
module sng_lfsr8 #(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] X,
  output logic       SN,
  output logic       sn_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] lfsr;
  logic [7:0] x_reg;
  logic [7:0] cnt;
  logic       fb;
  logic [7:0] lfsr_next;

  // The all-zero-low-bits term splices 0x00 into the cycle between 0x80 and 0x01.
  always_comb begin
    fb        = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3] ^ (lfsr[6:0] == 7'd0);
    lfsr_next = {lfsr[6:0], fb};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lfsr  <= SEED;
      x_reg <= 8'd0;
      cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            x_reg <= X;
            lfsr  <= SEED;
            cnt   <= 8'd0;
          end
        end
        RUN: begin
          lfsr <= lfsr_next;
          cnt  <= cnt + 8'd1;
          if (cnt == 8'd255) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign sn_valid = (state == RUN);
  assign SN       = (state == RUN) && (lfsr < x_reg);
  assign done     = (state == DONE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_sng_lfsr8.sv
// tb/tb_sng_lfsr8.sv - scoreboard bench for sng_lfsr8 across three seeds
// Expected ones-counts are queued at each accepted start and popped at the done pulse.
module tb_sng_lfsr8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x = 8'd0;
  logic [2:0] sn;
  logic [2:0] vld;
  logic [2:0] bsy;
  logic [2:0] dn;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  sng_lfsr8 #(.SEED(8'h01)) u_s01 (
    .clk(clk), .rst(rst), .start(start), .X(x),
    .SN(sn[0]), .sn_valid(vld[0]), .busy(bsy[0]), .done(dn[0])
  );
  sng_lfsr8 #(.SEED(8'h00)) u_s00 (
    .clk(clk), .rst(rst), .start(start), .X(x),
    .SN(sn[1]), .sn_valid(vld[1]), .busy(bsy[1]), .done(dn[1])
  );
  sng_lfsr8 #(.SEED(8'hB5)) u_sb5 (
    .clk(clk), .rst(rst), .start(start), .X(x),
    .SN(sn[2]), .sn_valid(vld[2]), .busy(bsy[2]), .done(dn[2])
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] nxt(input logic [7:0] s);
    logic f;
    f = s[7] ^ s[5] ^ s[4] ^ s[3] ^ (s[6:0] == 7'd0);
    return {s[6:0], f};
  endfunction

  // One full stream: accept, 256 RUN cycles, DONE, then the first IDLE cycle.
  task automatic run_stream(input logic [7:0] xv, input bit poke, input bit hold);
    logic [7:0]   m [3];
    int           ones [3];
    int           trace_err;
    logic [255:0] seen;
    bit           wrap_ok;
    int           zero_lfsr;
    logic [7:0]   cur;
    logic [7:0]   prev;
    m         = '{8'h01, 8'h00, 8'hB5};
    ones      = '{0, 0, 0};
    trace_err = 0;
    seen      = '0;
    wrap_ok   = 1'b1;
    zero_lfsr = -1;
    prev      = 8'd0;
    start = 1'b1;
    x     = xv;
    for (int k = 0; k < 3; k++) exp_q.push_back(int'(xv));
    tick();
    if (!hold) start = 1'b0;
    x = 8'd50;
    chk("sn_valid_rise", int'(vld), 7);
    for (int i = 0; i < 256; i++) begin
      cur = u_s01.lfsr;
      if (i > 0 && prev == 8'h80 && cur != 8'h00) wrap_ok = 1'b0;
      seen[cur] = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (sn[k] !== (m[k] < xv)) trace_err++;
        if (vld[k] !== 1'b1) trace_err++;
        if (dn[k] !== 1'b0) trace_err++;
        ones[k] += int'(sn[k]);
        m[k] = nxt(m[k]);
      end
      if (sn[0] == 1'b0) zero_lfsr = int'(cur);
      if (xv == 8'd2 && i < 2) chk($sformatf("x2_sn_cycle%0d", i + 1), int'(sn[0]), (i == 0) ? 1 : 0);
      prev = cur;
      if (poke && i == 8) start = 1'b1;
      if (poke && i == 9) start = 1'b0;
      tick();
    end
    chk("done_pulse", int'(dn), 7);
    chk("done_valid_low", int'(vld), 0);
    chk("done_busy", int'(bsy), 7);
    for (int k = 0; k < 3; k++) chk($sformatf("ones_count_dut%0d_x%0d", k, xv), ones[k], exp_q.pop_front());
    chk("sn_trace", trace_err, 0);
    chk("lfsr_cover", $countones(seen), 256);
    chk("lfsr_wrap_80_00", int'(wrap_ok), 1);
    if (xv == 8'd255) chk("x255_zero_at_ff", zero_lfsr, 255);
    if (poke) start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    chk("idle_busy", int'(bsy), 0);
    chk("idle_done", int'(dn), 0);
    chk("idle_valid", int'(vld), 0);
  endtask

  initial begin
    logic [7:0] sweep [6];
    int         bad;
    sweep = '{8'd0, 8'd1, 8'd127, 8'd128, 8'd200, 8'd255};

    rst = 1'b1;
    tick();
    tick();
    chk("rst_sn", int'(sn), 0);
    chk("rst_valid", int'(vld), 0);
    chk("rst_busy", int'(bsy), 0);
    chk("rst_done", int'(dn), 0);
    chk("rst_lfsr_seed", int'(u_sb5.lfsr), 8'hB5);
    rst = 1'b0;
    tick();
    chk("idle_no_start", int'(bsy), 0);

    run_stream(8'd2, 1'b0, 1'b0);

    for (int j = 0; j < 6; j++) run_stream(sweep[j], 1'b0, 1'b0);

    run_stream(8'd100, 1'b1, 1'b0);
    run_stream(8'd7, 1'b0, 1'b0);

    start = 1'b1;
    x     = 8'd33;
    tick();
    start = 1'b0;
    repeat (99) tick();
    chk("pre_reset_running", int'(vld), 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_sn", int'(sn), 0);
    chk("abort_valid", int'(vld), 0);
    chk("abort_busy", int'(bsy), 0);
    chk("abort_done", int'(dn), 0);
    bad = 0;
    repeat (300) begin
      if (dn !== 3'b000 || vld !== 3'b000 || bsy !== 3'b000) bad++;
      tick();
    end
    chk("no_done_after_abort", bad, 0);
    run_stream(8'd77, 1'b0, 1'b0);

    run_stream(8'd10, 1'b0, 1'b1);
    run_stream(8'd10, 1'b0, 1'b1);
    run_stream(8'd10, 1'b0, 1'b0);
    tick();
    chk("final_idle", int'(bsy), 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
